// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3 datapath: digest size, ASCII constants,
// the nibble-to-hex-character helper and the transmitter state encoding.
package sha3_pkg;

  localparam int SHA3_256_DIGEST_BITS = 256;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // Map a 4-bit value to its lowercase ASCII hex character.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_0 + {4'd0, n};
    end else begin
      return ASCII_A_LC + ({4'd0, n} - 8'd10);
    end
  endfunction

endpackage

// File: rtl/sha3_digest_tx.sv
// Digest transmitter: captures the SHA3 digest on the rising edge of the
// core's done level and streams it out byte-serially (raw or ASCII hex)
// over a valid/ready interface, lowest-addressed byte first.
module sha3_digest_tx
  import sha3_pkg::*;
#(
  parameter int DIGEST_BITS = SHA3_256_DIGEST_BITS,
  parameter bit HEX_ASCII   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   digest_done,
  input  logic [DIGEST_BITS-1:0] digest_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_last,
  output logic                   busy,
  output logic                   tx_complete,
  output logic                   overrun
);

  localparam int NBYTES = DIGEST_BITS / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  tx_state_t              state;
  logic                   done_d;
  logic                   cap;
  logic                   hs;
  logic [DIGEST_BITS-1:0] shadow;
  logic [IDX_W-1:0]       byte_idx;
  logic                   nib;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   nib_nxt;

  // Character (or raw byte) presented for a given byte index and nibble phase.
  function automatic logic [7:0] beat_byte(input logic [DIGEST_BITS-1:0] sh,
                                           input logic [IDX_W-1:0]       idx,
                                           input logic                   n);
    logic [7:0] b;
    b = 8'(sh >> {idx, 3'b000});
    if (HEX_ASCII) begin
      return nib2ascii(n ? b[3:0] : b[7:4]);
    end else begin
      return b;
    end
  endfunction

  // True when the given position is the final beat of the digest.
  function automatic logic beat_is_last(input logic [IDX_W-1:0] idx,
                                        input logic             n);
    if (HEX_ASCII) begin
      return (idx == LAST_IDX) && n;
    end else begin
      return idx == LAST_IDX;
    end
  endfunction

  assign cap = digest_done && !done_d;
  assign hs  = tx_valid && tx_ready;

  // Position of the beat following the current one; hex mode walks both nibbles of a byte.
  always_comb begin
    idx_nxt = byte_idx;
    nib_nxt = 1'b0;
    if (HEX_ASCII) begin
      nib_nxt = ~nib;
      if (nib) begin
        idx_nxt = byte_idx + IDX_W'(1);
      end
    end else begin
      idx_nxt = byte_idx + IDX_W'(1);
    end
  end

  // Digest shadow copy; only loaded on an accepted capture, so later core activity cannot disturb it.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cap) begin
      shadow <= digest_in;
    end
  end

  // Capture/transmit FSM with registered stream outputs and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      done_d      <= 1'b0;
      byte_idx    <= '0;
      nib         <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      tx_complete <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done_d      <= digest_done;
      tx_complete <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cap) begin
            state    <= ST_SEND;
            byte_idx <= '0;
            nib      <= 1'b0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            tx_data  <= beat_byte(digest_in, '0, 1'b0);
            tx_last  <= beat_is_last('0, 1'b0);
          end
        end
        ST_SEND: begin
          // A new digest while still sending is dropped, including on the final handshake.
          if (cap) begin
            overrun <= 1'b1;
          end
          if (hs) begin
            if (tx_last) begin
              state       <= ST_IDLE;
              tx_valid    <= 1'b0;
              busy        <= 1'b0;
              tx_last     <= 1'b0;
              tx_data     <= 8'h00;
              tx_complete <= 1'b1;
            end else begin
              byte_idx <= idx_nxt;
              nib      <= nib_nxt;
              tx_data  <= beat_byte(shadow, idx_nxt, nib_nxt);
              tx_last  <= beat_is_last(idx_nxt, nib_nxt);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_digest_tx.sv
// Bench for sha3_digest_tx: a raw-mode and a hex-mode instance share the
// stimulus; accepted beats are collected and compared with sequences
// derived directly from the digest value.
module tb_sha3_digest_tx;

  logic         clk;
  logic         rst;
  logic         done;
  logic [255:0] din;
  logic         ready;

  logic [7:0] r_data, h_data;
  logic       r_valid, h_valid, r_last, h_last, r_busy, h_busy;
  logic       r_cmpl, h_cmpl, r_ovr, h_ovr;

  sha3_digest_tx #(.DIGEST_BITS(256), .HEX_ASCII(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .digest_done(done), .digest_in(din),
    .tx_data(r_data), .tx_valid(r_valid), .tx_ready(ready), .tx_last(r_last),
    .busy(r_busy), .tx_complete(r_cmpl), .overrun(r_ovr));

  sha3_digest_tx #(.DIGEST_BITS(256), .HEX_ASCII(1'b1)) dut_hex (
    .clk(clk), .rst(rst), .digest_done(done), .digest_in(din),
    .tx_data(h_data), .tx_valid(h_valid), .tx_ready(ready), .tx_last(h_last),
    .busy(h_busy), .tx_complete(h_cmpl), .overrun(h_ovr));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 3;

  logic [7:0] rq[$], hq[$];
  bit         rlq[$], hlq[$];
  int         rcq[$];
  int         r_cn = 0, h_cn = 0, r_ccyc = 0;
  int         r_viol = 0, h_viol = 0;
  bit         r_hv = 0, h_hv = 0;
  logic [7:0] r_hd, h_hd;
  bit         r_hl, h_hl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern selected by the running test.
  initial begin
    int ph;
    ph = 0;
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: ready = 1'b1;
        1: begin ready = (ph % 3 == 0); ph++; end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
    end
  end

  // Record beats accepted at the coming edge, completion pulses and stall stability.
  always @(negedge clk) begin
    if (r_valid && ready) begin
      rq.push_back(r_data);
      rlq.push_back(r_last);
      rcq.push_back(cyc + 1);
    end
    if (h_valid && ready) begin
      hq.push_back(h_data);
      hlq.push_back(h_last);
    end
    if (r_cmpl) begin
      r_cn   <= r_cn + 1;
      r_ccyc <= cyc;
    end
    if (h_cmpl) h_cn <= h_cn + 1;
    if (r_hv && (!r_valid || r_data != r_hd || r_last != r_hl)) r_viol <= r_viol + 1;
    if (h_hv && (!h_valid || h_data != h_hd || h_last != h_hl)) h_viol <= h_viol + 1;
    r_hv <= r_valid && !ready && !rst;
    h_hv <= h_valid && !ready && !rst;
    r_hd <= r_data;
    r_hl <= r_last;
    h_hd <= h_data;
    h_hl <= h_last;
  end

  function automatic logic [7:0] hexc(input logic [3:0] v);
    return (v < 4'd10) ? 8'(48 + int'(v)) : 8'(87 + int'(v));
  endfunction

  // Expected raw stream packed beat k at bits [8k+7:8k]: simply the digest.
  function automatic logic [511:0] exp_raw(input logic [255:0] d);
    return {256'd0, d};
  endfunction

  // Expected hex stream: byte i becomes chars 2i (high nibble) and 2i+1 (low nibble).
  function automatic logic [511:0] exp_hex(input logic [255:0] d);
    logic [511:0] e;
    for (int i = 0; i < 32; i++) begin
      e[16*i +: 8]     = hexc(d[8*i+4 +: 4]);
      e[16*i + 8 +: 8] = hexc(d[8*i +: 4]);
    end
    return e;
  endfunction

  function automatic logic [511:0] pack_bytes(input int base, input bit hex);
    logic [511:0] a;
    int n;
    a = '0;
    n = hex ? hq.size() - base : rq.size() - base;
    for (int k = 0; k < n && k < 64; k++) a[8*k +: 8] = hex ? hq[base+k] : rq[base+k];
    return a;
  endfunction

  function automatic logic [63:0] pack_last(input int base, input bit hex);
    logic [63:0] m;
    int n;
    m = '0;
    n = hex ? hlq.size() - base : rlq.size() - base;
    for (int k = 0; k < n && k < 64; k++) m[k] = hex ? hlq[base+k] : rlq[base+k];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    done = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Raise digest_done with a new digest; returns the cycle number of the capturing edge.
  task automatic launch(input logic [255:0] d, output int cap_cyc);
    din  = d;
    done = 1'b1;
    tick(1);
    cap_cyc = cyc;
  endtask

  task automatic wait_cmpl(input bit hex, input int base_n, input int budget, input string nm);
    int b;
    b = budget;
    while ((hex ? h_cn : r_cn) <= base_n && b > 0) begin
      tick(1);
      b--;
    end
    if (b == 0) chk({nm, "_timeout"}, 512'd0, 512'd1);
  endtask

  typedef struct {
    logic [255:0] d;
    int           mode;
    int           raw_beats;
    int           hex_beats;
  } vec_t;

  vec_t vt[4];
  logic [255:0] empty_d, be, da, db, dc;
  int rb, hb, rn, hn, rv, hv, cap, n0;

  initial begin
    rst = 1'b1;
    done = 1'b0;
    din = '0;

    be = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    for (int i = 0; i < 32; i++) empty_d[8*i +: 8] = be[255-8*i -: 8];
    for (int i = 0; i < 8; i++) begin
      da[32*i +: 32] = $urandom;
      db[32*i +: 32] = $urandom;
      dc[32*i +: 32] = $urandom;
    end
    vt[0] = '{empty_d, 0, 32, 64};
    vt[1] = '{empty_d, 1, 32, 64};
    vt[2] = '{da,      2, 32, 64};
    vt[3] = '{db,      1, 32, 64};

    do_reset();
    chk("reset_raw", 512'({r_valid, r_data, r_last, r_busy, r_cmpl, r_ovr}), 512'd0);
    chk("reset_hex", 512'({h_valid, h_data, h_last, h_busy, h_cmpl, h_ovr}), 512'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      mode = vt[v].mode;
      rb = rq.size(); hb = hq.size(); rn = r_cn; hn = h_cn; rv = r_viol; hv = h_viol;
      launch(vt[v].d, cap);
      chk($sformatf("v%0d_first_raw", v), 512'({r_valid, r_busy, r_data}),
          512'({1'b1, 1'b1, vt[v].d[7:0]}));
      chk($sformatf("v%0d_first_hex", v), 512'({h_valid, h_busy, h_data}),
          512'({1'b1, 1'b1, hexc(vt[v].d[7:4])}));
      wait_cmpl(1'b0, rn, 1000, $sformatf("v%0d_raw", v));
      wait_cmpl(1'b1, hn, 1000, $sformatf("v%0d_hex", v));
      tick(3);
      chk($sformatf("v%0d_raw_beats", v), 512'(rq.size() - rb), 512'(vt[v].raw_beats));
      chk($sformatf("v%0d_hex_beats", v), 512'(hq.size() - hb), 512'(vt[v].hex_beats));
      chk($sformatf("v%0d_raw_data", v), pack_bytes(rb, 1'b0), exp_raw(vt[v].d));
      chk($sformatf("v%0d_hex_data", v), pack_bytes(hb, 1'b1), exp_hex(vt[v].d));
      chk($sformatf("v%0d_raw_last", v), 512'(pack_last(rb, 1'b0)), 512'(64'd1 << 31));
      chk($sformatf("v%0d_hex_last", v), 512'(pack_last(hb, 1'b1)), 512'(64'd1 << 63));
      chk($sformatf("v%0d_stall", v), 512'((r_viol - rv) + (h_viol - hv)), 512'd0);
      chk($sformatf("v%0d_cmpl_cnt", v), 512'({r_cn - rn, h_cn - hn}), 512'({32'd1, 32'd1}));
      chk($sformatf("v%0d_idle", v), 512'({r_busy, r_valid, r_ovr, h_busy, h_valid, h_ovr}), 512'd0);
      if (v == 0) begin
        chk("empty_hex_head", 512'({hq[hb], hq[hb+1], hq[hb+2], hq[hb+3]}), 512'(32'h61376666));
        chk("timing_first_hs", 512'(rcq[rb]), 512'(cap + 1));
        chk("timing_last_hs", 512'(rcq[rb+31]), 512'(cap + 32));
        chk("timing_cmpl", 512'(r_ccyc), 512'(cap + 32));
      end
      done = 1'b0;
    end

    // Level held high, then a second rising edge while the first digest is still going out.
    do_reset();
    mode = 1;
    rb = rq.size(); rn = r_cn;
    launch(da, cap);
    tick(25);
    done = 1'b0;
    tick(1);
    din = db;
    done = 1'b1;
    tick(1);
    chk("ovr_set", 512'({r_ovr, r_busy}), 512'({1'b1, 1'b1}));
    wait_cmpl(1'b0, rn, 1000, "ovr_raw");
    tick(1);
    chk("ovr_data", pack_bytes(rb, 1'b0), exp_raw(da));
    chk("ovr_after_cmpl", 512'(r_ovr), 512'd1);
    tick(60);
    chk("ovr_no_second", 512'(rq.size() - rb), 512'd32);
    chk("ovr_sticky", 512'({r_ovr, r_busy}), 512'({1'b1, 1'b0}));
    done = 1'b0;

    // Reset in the middle of a transfer after an overrun has been flagged.
    do_reset();
    mode = 0;
    rb = rq.size();
    launch(da, cap);
    done = 1'b0;
    tick(1);
    din = db;
    done = 1'b1;
    tick(1);
    chk("rst_pre_ovr", 512'(r_ovr), 512'd1);
    n0 = 40;
    while (rq.size() - rb < 5 && n0 > 0) begin
      tick(1);
      n0--;
    end
    if (n0 == 0) chk("rst_wait_timeout", 512'd0, 512'd1);
    rst = 1'b1;
    done = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_raw", 512'({r_valid, r_busy, r_ovr}), 512'd0);
    chk("rst_mid_hex", 512'({h_valid, h_busy, h_ovr}), 512'd0);
    rb = rq.size();
    tick(4);
    chk("rst_no_beats", 512'(rq.size() - rb), 512'd0);
    rn = r_cn;
    launch(dc, cap);
    wait_cmpl(1'b0, rn, 200, "rst_fresh");
    tick(1);
    chk("rst_fresh_data", pack_bytes(rb, 1'b0), exp_raw(dc));
    done = 1'b0;

    // Rising edge arrives on the same edge as the final handshake.
    do_reset();
    mode = 0;
    rb = rq.size(); rn = r_cn;
    launch(db, cap);
    tick(3);
    done = 1'b0;
    tick(cap + 31 - cyc);
    din = da;
    done = 1'b1;
    tick(1);
    chk("coin_state", 512'({r_ovr, r_valid, r_busy, r_cmpl}), 512'({1'b1, 1'b0, 1'b0, 1'b1}));
    wait_cmpl(1'b0, rn, 10, "coin");
    tick(60);
    chk("coin_data", pack_bytes(rb, 1'b0), exp_raw(db));
    chk("coin_no_second", 512'({rq.size() - rb, r_cn - rn}), 512'({32'd32, 32'd1}));
    chk("coin_final", 512'({r_ovr, r_busy, r_valid}), 512'({1'b1, 1'b0, 1'b0}));
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha3_digest_tx.md
Name: sha3_digest_tx

Overview:
Output-side transmitter for the SHA3 hashing datapath. It captures the 256-bit digest when the core's level-type done rises, then serialises it over a byte-wide valid/ready stream, as raw bytes or as lowercase ASCII hex. It sits between the SHA3 top-level core and the UART/host byte link, mirroring the byte-serial message input on the other side of the core.

Parameters:
DIGEST_BITS, 256, digest width; must be a multiple of 8 (256 for SHA3-256).
HEX_ASCII, 0, 0 = raw bytes (DIGEST_BITS/8 beats); 1 = two lowercase ASCII hex chars per byte (DIGEST_BITS/4 beats).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
digest_done  in  1  level from core, high while the digest is valid
digest_in  in  DIGEST_BITS  digest from core, sampled on the rising edge of digest_done
tx_data  out  8  stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts when tx_valid && tx_ready
tx_last  out  1  high with the final beat of a digest
busy  out  1  high from capture until the last beat is accepted
tx_complete  out  1  one-cycle pulse after the last beat is accepted
overrun  out  1  sticky; a new digest arrived while busy

Behaviour:
- Reset (synchronous, clk edge with rst=1): tx_valid=0, tx_data=0, tx_last=0, busy=0, tx_complete=0, overrun=0, FSM=IDLE, counters=0, done_d=0. Reset mid-transfer drops the digest with no further beats.
- Edge detect: done_d registers digest_done. cap = digest_done && !done_d. A level held high yields exactly one capture.
- FSM states: IDLE, SEND.
  - IDLE: on cap, latch digest_in into shadow register, byte_idx=0, nib=0, go to SEND. tx_valid=1 and busy=1 from the next cycle (1-cycle latency from the rising edge).
  - SEND, on handshake (tx_valid && tx_ready):
    - Raw mode: advance byte_idx.
    - Hex mode: toggle nib; advance byte_idx when nib was 1.
    - Last beat accepted: go to IDLE; tx_valid=0, busy=0, tx_last=0, tx_complete=1 for one cycle.
  - SEND without handshake: tx_data, tx_last and tx_valid hold stable. tx_valid never drops before acceptance.
- Byte order (FIPS 202 lane order): byte i = shadow[8i+7:8i], i = 0 first.
- Hex mode: high nibble first. 0-9 map to 0x30-0x39; a-f map to 0x61-0x66.
- tx_last = 1 exactly when the current beat is index DIGEST_BITS/8-1 (raw), or that byte with nib=1 (hex).
- Back-to-back: a handshake every cycle when tx_ready is held high. Raw 256-bit transfer = 32 beats in 32 cycles.
- cap while in SEND: digest ignored, shadow untouched, overrun set to 1. overrun stays set until rst.
- cap in the same cycle as the final handshake: treated as busy; overrun sets, digest ignored.
- digest_done falling mid-transfer: no effect on the transfer. digest_in changing after capture: no effect.
- Counter widths: byte_idx = $clog2(DIGEST_BITS/8) bits. No wrap past the last index; FSM exits first.

Decomposition:
- Shared package sha3_pkg:
  - SHA3_256_DIGEST_BITS = 256.
  - ASCII_0 = 8'h30, ASCII_A_LC = 8'h61.
  - Function nib2ascii(4-bit) -> 8-bit.
  - FSM state encoding typedef.
- No sub-module needed; the byte/nibble mux and the FSM stay in one module.

Test Plan:
- Raw, tx_ready=1, digest of SHA3-256("") (digest_in[7:0]=8'ha7, [15:8]=8'hff, ..., [255:248]=8'h4a) with digest_done rising at cycle T -> beats a7,ff,c6,...,4a on cycles T+1..T+32; tx_last only on 4a; tx_complete at T+33; busy low after.
- HEX_ASCII=1, same digest -> 64 beats "a7ffc6f8...80f8434a" (0x61,0x37,0x66,0x66,...); tx_last on final 0x61.
- Raw, tx_ready toggling 1,0,0,1,... -> tx_data/tx_valid/tx_last stable during stalls; byte sequence identical to the first test; total beats = 32.
- digest_done held high 100 cycles, then a new rising edge at beat 10 -> only one transfer from the first edge, overrun=1 and stays 1 through tx_complete; second digest never sent.
- rst asserted at beat 5 of a transfer -> next cycle tx_valid=0, busy=0, overrun=0; a fresh rising edge then sends the new digest from byte 0.
- Rising edge of digest_done in the same cycle as the final handshake -> transfer completes normally; overrun=1; FSM returns to IDLE with no second transfer.
